// File: rtl/video_timing_pkg.sv
// Shared constants and types for the video timing source.
// Holds 1080p60 timing defaults, colour-bar palette and pattern select enum.
package video_timing_pkg;

    // 1080p60 raster: 2200 x 1125 total
    localparam int DEF_H_ACTIVE = 1920;
    localparam int DEF_H_FP     = 88;
    localparam int DEF_H_SYNC   = 44;
    localparam int DEF_H_BP     = 148;
    localparam int DEF_V_ACTIVE = 1080;
    localparam int DEF_V_FP     = 4;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 36;

    typedef enum logic {
        PAT_BARS = 1'b0,
        PAT_RAMP = 1'b1
    } pat_sel_e;

    // Left-to-right bar order
    localparam logic [23:0] BAR_RGB [0:7] = '{
        24'hFFFFFF,  // white
        24'hFFFF00,  // yellow
        24'h00FFFF,  // cyan
        24'h00FF00,  // green
        24'hFF00FF,  // magenta
        24'hFF0000,  // red
        24'h0000FF,  // blue
        24'h000000   // black
    };

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational test-pattern generator: colour bars or grey ramp.
// Ports: bar_idx/hcnt/active/vid_sel in, rgb out (zero outside active video).
module video_pattern_gen
    import video_timing_pkg::*;
(
    input  logic [2:0]  bar_idx,
    input  logic [11:0] hcnt,
    input  logic        active,
    input  logic        vid_sel,
    output logic [23:0] rgb
);

    always_comb begin
        rgb = '0;
        if (active) begin
            if (pat_sel_e'(vid_sel) == PAT_RAMP)
                rgb = {3{hcnt[10:3]}};
            else
                rgb = BAR_RGB[bar_idx];
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: blanking, syncs, position, frame count, test pattern.
// Ports: clk_i, rst_n_i (sync, active-low), cen_i, vid_sel_i in;
//        vid_rgb_o, vh_blank_o, dvh_sync_o, x_o, y_o, sof_o, frame_cnt_o out.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cen_i,
    input  logic        vid_sel_i,
    output logic [23:0] vid_rgb_o,
    output logic [1:0]  vh_blank_o,
    output logic [2:0]  dvh_sync_o,
    output logic [11:0] x_o,
    output logic [10:0] y_o,
    output logic        sof_o,
    output logic [7:0]  frame_cnt_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] HA       = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);
    localparam logic [10:0] VA       = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);

    logic [11:0] hcnt;
    logic [10:0] vcnt;
    logic [7:0]  fcnt;
    logic [11:0] bar_pix;
    logic [2:0]  bar_idx;

    logic        h_end;
    logic        v_end;
    logic        hblank;
    logic        vblank;
    logic        active;
    logic        hsync;
    logic        vsync;
    logic [23:0] rgb;

    always_comb begin
        h_end  = (hcnt == H_LAST);
        v_end  = (vcnt == V_LAST);
        hblank = (hcnt >= HA);
        vblank = (vcnt >= VA);
        active = ~hblank & ~vblank;
        hsync  = (hcnt >= HS_BEG) && (hcnt < HS_END) ? HS_POL : ~HS_POL;
        vsync  = (vcnt >= VS_BEG) && (vcnt < VS_END) ? VS_POL : ~VS_POL;
    end

    video_pattern_gen u_pattern (
        .bar_idx (bar_idx),
        .hcnt    (hcnt),
        .active  (active),
        .vid_sel (vid_sel_i),
        .rgb     (rgb)
    );

    // Raster counters. The bar sub-counter tracks hcnt so the bar index
    // is available without dividing hcnt by the bar width.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            hcnt    <= '0;
            vcnt    <= '0;
            fcnt    <= '0;
            bar_pix <= '0;
            bar_idx <= '0;
        end else if (cen_i) begin
            if (h_end) begin
                hcnt    <= '0;
                bar_pix <= '0;
                bar_idx <= '0;
                if (v_end) begin
                    vcnt <= '0;
                    fcnt <= fcnt + 8'd1;
                end else begin
                    vcnt <= vcnt + 11'd1;
                end
            end else begin
                hcnt <= hcnt + 12'd1;
                if (bar_pix == BAR_LAST) begin
                    bar_pix <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_pix <= bar_pix + 12'd1;
                end
            end
        end
    end

    // Outputs carry the decode of the pre-increment position, so the
    // frame count changes together with the sof pixel.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            vid_rgb_o   <= '0;
            vh_blank_o  <= 2'b11;
            dvh_sync_o  <= {1'b0, ~VS_POL, ~HS_POL};
            x_o         <= '0;
            y_o         <= '0;
            sof_o       <= 1'b0;
            frame_cnt_o <= '0;
        end else if (cen_i) begin
            vid_rgb_o   <= rgb;
            vh_blank_o  <= {vblank, hblank};
            dvh_sync_o  <= {active, vsync, hsync};
            x_o         <= hcnt;
            y_o         <= vcnt;
            sof_o       <= (hcnt == '0) && (vcnt == '0);
            frame_cnt_o <= fcnt;
        end
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Source end of the video timing interface consumed by the video processing stage.
- Generates raster timing (`vh_blank`, `dvh_sync`) plus a test-pattern RGB stream; default timing is 1080p60 (2200x1125 total).
- Sits upstream of the processing stage and drives its `vid_rgb_i`, `vh_blank_i` and `dvh_sync_i` inputs directly.
- Advances one pixel per `cen_i`, so it shares the processing stage's clock and clock enable.

Parameters:
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch (pixels)
- H_SYNC, 44, hsync width (pixels)
- H_BP, 148, horizontal back porch (pixels)
- V_ACTIVE, 1080, active lines per frame
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 36, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous reset, active-low
- cen_i  in  1  pixel clock enable
- vid_sel_i  in  1  pattern select: 0 = colour bars, 1 = grey ramp
- vid_rgb_o  out  24  R[23:16], G[15:8], B[7:0]
- vh_blank_o  out  2  {Vblank, Hblank}
- dvh_sync_o  out  3  {D_sync (active video), Vsync, Hsync}
- x_o  out  12  horizontal position of the current output pixel
- y_o  out  11  vertical position of the current output pixel
- sof_o  out  1  start-of-frame strobe, high for the pixel at (0,0)
- frame_cnt_o  out  8  frame counter

Behaviour:
- Interface decisions (already decided): one clock `clk_i`; reset `rst_n_i` is synchronous and active-low.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way from the V parameters.
- Counters hcnt (12b) and vcnt (11b) reset to 0 and advance only when cen_i=1. cen_i=0 holds all state and all outputs.
- Line layout: hcnt 0..H_ACTIVE-1 is active video, then front porch, sync, back porch. Vertical layout is identical, in lines.
- Horizontal wrap: hcnt==H_TOTAL-1 → hcnt=0 and vcnt increments.
- Frame wrap: when hcnt==H_TOTAL-1 and vcnt==V_TOTAL-1 on the same cen, both counters go to 0 and frame_cnt increments, wrapping 255→0.
- All outputs are registered. On each cen they load the decode of the pre-increment (hcnt,vcnt), so outputs lag the counters by one cen.
- Decode rules:
  - Hblank = (hcnt >= H_ACTIVE); Vblank = (vcnt >= V_ACTIVE).
  - D_sync = ~Hblank & ~Vblank.
  - Hsync is active for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - Vsync is active for entire lines with vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - Output level of each sync = POL when active, ~POL when inactive.
- x_o/y_o = decoded hcnt/vcnt; they keep counting through blanking.
- sof_o = 1 only for the output pixel at hcnt==0 and vcnt==0.
- Colour bars (vid_sel_i=0):
  - BAR_W = H_ACTIVE/8.
  - A 3-bit bar index is maintained by a sub-counter that resets at hcnt=0 and steps every BAR_W active pixels. No divider.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black. Components are FF or 00, e.g. yellow = FFFF00.
- Grey ramp (vid_sel_i=1): R=G=B = hcnt[10:3].
- vid_sel_i is sampled every cen, so a mid-line change takes effect on the next output pixel.
- vid_rgb_o = 0 whenever D_sync = 0.
- Reset values, applied on the clock edge with rst_n_i=0 regardless of cen_i:
  - vid_rgb_o=0, vh_blank_o=2'b11, dvh_sync_o={0,~VS_POL,~HS_POL}
  - x_o=0, y_o=0, sof_o=0, frame_cnt_o=0
- Reset mid-frame discards the raster position. The first cen after release outputs pixel (0,0) with sof_o=1.

Decomposition:
- Package video_timing_pkg holds:
  - 1080p60 timing constants;
  - the 8-entry colour-bar RGB constant array;
  - the pattern-select enum (PAT_BARS, PAT_RAMP).
- One sub-module, video_pattern_gen: maps bar index, hcnt, active flag and vid_sel to RGB. It is purely combinational; it is instantiated before the output registers.

Test Plan:
- Reduced timing: H 16/2/2/4 (H_TOTAL 24), V 8/1/1/2 (V_TOTAL 12), cen_i=1, 600 cycles:
  - Hblank period is 24 cycles, high for 8 of them; Hsync is high on x=18,19.
  - Vsync is high for all of y=9; sof_o pulses every 288 cycles; frame_cnt_o increments once per 288 cycles.
- 1080p defaults, one full frame: exactly 1920x1080 D_sync=1 pixels; 2,475,000 cycles per frame.
- Colour bars, reduced timing (BAR_W=2): line 0 RGB sequence FFFFFF x2, FFFF00 x2, 00FFFF x2 … 000000 x2, then 000000 for the blank pixels.
- cen_i toggling 1/0: every output is unchanged on cen=0 cycles; the sequence equals the cen=1 run with each value held over its cen=0 cycle.
- Reset at (x=5, y=3) with HS_POL=0, VS_POL=0:
  - Next clock: vh_blank_o=11, dvh_sync_o=3'b011, frame_cnt_o=0.
  - First cen after release: x_o=0, y_o=0, sof_o=1.
- frame_cnt_o wrap: run 256 reduced-timing frames → frame_cnt_o returns from 255 to 0 on the sof_o pixel.
